// File: rtl/tx_pll_reset_sequencer.sv
// TX clock PLL supervisor.
// Runs on the free-running 50 MHz reference clock. It pulses the PLL reset,
// waits for and qualifies lock, then releases the three TX-clock-domain resets
// one at a time. A lock timeout or an unstable lock counts as a failed attempt
// and is retried up to MAX_RETRIES times before parking in FAULT. Losing lock
// after release starts a fresh sequence rather than a retry.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   RESET_PLL | pll_rst held high for PLL_RST_CYCLES, all domains in reset
//   WAIT_LOCK | pll_rst released, waiting up to LOCK_TIMEOUT_CYCLES for lock
//   STABLE    | lock seen, requiring LOCK_STABLE_CYCLES consecutive lock
//   RELEASE   | stepping domain resets out, RELEASE_GAP_CYCLES apart
//   RUN       | all domains out of reset, watching for lock loss
//   FAULT     | retries exhausted, PLL held in reset until rst/restart
module tx_pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int RELEASE_GAP_CYCLES  = 8,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic [2:0] rst_out,
    output logic       clocks_ready,
    output logic       lock_lost,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    // Terminal counts for the shared up-counter; each state restarts it at 0.
    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP          = CNT_W'(RELEASE_GAP_CYCLES);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(2 * RELEASE_GAP_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic [3:0]       retry_nxt;
    logic             fail_attempt;
    logic             lock_lost_nxt;
    logic             lock_meta;
    logic             lock_s;

    logic             pll_rst_nxt;
    logic [2:0]       rst_out_nxt;
    logic             clocks_ready_nxt;
    logic             fault_nxt;

    // Two-flop synchronizer for the asynchronous lock flag; it carries no
    // reset so it keeps tracking the PLL while the sequencer is held in rst.
    always_ff @(posedge refclk) begin
        lock_meta <= pll_locked;
        lock_s    <= lock_meta;
    end

    // State register together with the cycle counter and retry counter.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r     <= S_RESET_PLL;
            cnt_r       <= '0;
            retry_count <= '0;
        end else begin
            state_r     <= state_nxt;
            cnt_r       <= cnt_nxt;
            retry_count <= retry_nxt;
        end
    end

    // Next-state logic: restart first, then lock loss / timeout, then progress.
    always_comb begin
        state_nxt     = state_r;
        cnt_nxt       = cnt_r;
        retry_nxt     = retry_count;
        fail_attempt  = 1'b0;
        lock_lost_nxt = 1'b0;

        if (restart) begin
            state_nxt = S_RESET_PLL;
            cnt_nxt   = '0;
            retry_nxt = '0;
        end else begin
            case (state_r)
                S_RESET_PLL: begin
                    if (cnt_r == RST_LAST) begin
                        state_nxt = S_WAIT_LOCK;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + 1'b1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = S_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt_r == TIMEOUT_LAST) begin
                        fail_attempt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_r + 1'b1;
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        fail_attempt = 1'b1;
                    end else if (cnt_r == STABLE_LAST) begin
                        state_nxt = S_RELEASE;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!lock_s) begin
                        lock_lost_nxt = 1'b1;
                    end else if (cnt_r == RELEASE_LAST) begin
                        state_nxt = S_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt_r + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        lock_lost_nxt = 1'b1;
                    end
                end
                S_FAULT: begin
                    state_nxt = S_FAULT;
                end
                default: begin
                    state_nxt = S_RESET_PLL;
                    cnt_nxt   = '0;
                    retry_nxt = '0;
                end
            endcase

            // Lock loss after release is a brand-new sequence, not a retry.
            if (lock_lost_nxt) begin
                state_nxt = S_RESET_PLL;
                cnt_nxt   = '0;
                retry_nxt = '0;
            end

            if (fail_attempt) begin
                cnt_nxt = '0;
                if (retry_count < RETRY_MAX) begin
                    retry_nxt = retry_count + 4'd1;
                    state_nxt = S_RESET_PLL;
                end else begin
                    state_nxt = S_FAULT;
                end
            end
        end
    end

    // Output decode from the upcoming state so every output is a flop.
    // In RELEASE the counter position picks how many domains are already out.
    always_comb begin
        pll_rst_nxt      = (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
        clocks_ready_nxt = (state_nxt == S_RUN);
        fault_nxt        = (state_nxt == S_FAULT);
        rst_out_nxt      = 3'b111;
        if (state_nxt == S_RELEASE) begin
            rst_out_nxt = (cnt_nxt < GAP) ? 3'b110 : 3'b100;
        end else if (state_nxt == S_RUN) begin
            rst_out_nxt = 3'b000;
        end
    end

    // Output registers.
    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_rst      <= 1'b1;
            rst_out      <= 3'b111;
            clocks_ready <= 1'b0;
            lock_lost    <= 1'b0;
            fault        <= 1'b0;
        end else begin
            pll_rst      <= pll_rst_nxt;
            rst_out      <= rst_out_nxt;
            clocks_ready <= clocks_ready_nxt;
            lock_lost    <= lock_lost_nxt;
            fault        <= fault_nxt;
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_tx_pll_reset_sequencer.sv
// Bench for tx_pll_reset_sequencer: a table of the clean-lock sequence,
// directed corner-case sequences, then random traffic against a model.
module tb_tx_pll_reset_sequencer;

    localparam int P_RST   = 4;
    localparam int P_STAB  = 8;
    localparam int P_TO    = 32;
    localparam int P_GAP   = 2;
    localparam int P_RETRY = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic [2:0] rst_out;
    logic       clocks_ready;
    logic       lock_lost;
    logic       fault;
    logic [3:0] retry_count;
    logic [2:0] state;

    int    checks = 0;
    int    errors = 0;
    string phase = "init";

    tx_pll_reset_sequencer #(
        .PLL_RST_CYCLES(P_RST),
        .LOCK_STABLE_CYCLES(P_STAB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .RELEASE_GAP_CYCLES(P_GAP),
        .MAX_RETRIES(P_RETRY),
        .CNT_W(16)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .restart(restart),
        .pll_locked(pll_locked),
        .pll_rst(pll_rst),
        .rst_out(rst_out),
        .clocks_ready(clocks_ready),
        .lock_lost(lock_lost),
        .fault(fault),
        .retry_count(retry_count),
        .state(state)
    );

    always #5 refclk = ~refclk;

    // Reference model: phase number (0..5), time spent in that phase, retries.
    int   m_state = 0;
    int   m_age = 0;
    int   m_retry = 0;
    logic m_ll = 1'b0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;

    task automatic m_enter(input int s);
        m_state = s;
        m_age   = 0;
    endtask

    task automatic m_fail();
        if (m_retry < P_RETRY) begin
            m_retry++;
            m_enter(0);
        end else begin
            m_enter(5);
        end
    endtask

    task automatic model_step(input logic r, input logic rs, input logic lk);
        logic seen;
        seen = h2;
        h2   = h1;
        h1   = lk;
        m_ll = 1'b0;
        if (r || rs) begin
            m_retry = 0;
            m_enter(0);
        end else begin
            case (m_state)
                0: if (m_age == P_RST - 1) m_enter(1); else m_age++;
                1: if (seen) m_enter(2);
                   else if (m_age == P_TO - 1) m_fail();
                   else m_age++;
                2: if (!seen) m_fail();
                   else if (m_age == P_STAB - 1) m_enter(3);
                   else m_age++;
                3, 4: if (!seen) begin
                          m_ll    = 1'b1;
                          m_retry = 0;
                          m_enter(0);
                      end else if (m_state == 3 && m_age == 2 * P_GAP - 1) begin
                          m_enter(4);
                      end else begin
                          m_age++;
                      end
                default: ;
            endcase
        end
    endtask

    function automatic logic [13:0] model_vec();
        logic [2:0] ones;
        logic [2:0] ro;
        ones = 3'b111;
        if (m_state == 3)      ro = ones << (1 + m_age / P_GAP);
        else if (m_state == 4) ro = 3'b000;
        else                   ro = 3'b111;
        return {3'(m_state), (m_state == 0 || m_state == 5), ro, (m_state == 4),
                m_ll, (m_state == 5), 4'(m_retry)};
    endfunction

    function automatic logic [13:0] dut_vec();
        return {state, pll_rst, rst_out, clocks_ready, lock_lost, fault, retry_count};
    endfunction

    task automatic report(input string name, input logic [13:0] a, input logic [13:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got st=%0d pr=%b ro=%b cr=%b ll=%b f=%b rc=%0d, required st=%0d pr=%b ro=%b cr=%b ll=%b f=%b rc=%0d",
                     name, a[13:11], a[10], a[9:7], a[6], a[5], a[4], a[3:0],
                     e[13:11], e[10], e[9:7], e[6], e[5], e[4], e[3:0]);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising
    // edge, sample at the next falling edge.
    task automatic tick(input logic r, input logic rs, input logic lk, input bit cmp);
        rst        = r;
        restart    = rs;
        pll_locked = lk;
        @(posedge refclk);
        model_step(r, rs, lk);
        @(negedge refclk);
        if (cmp) report(phase, dut_vec(), model_vec());
    endtask

    task automatic run_until(input int target, input int budget, input logic lk, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick(1'b0, 1'b0, lk, 1'b1);
            if (int'(state) == target) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: state=%0d, required state %0d within %0d cycles", name, state, target, budget);
        end
    endtask

    typedef struct {
        logic       r;
        logic       rs;
        logic       lk;
        logic [2:0] st;
        logic       pr;
        logic [2:0] ro;
        logic       cr;
        logic [3:0] rc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic [2:0] st, input logic pr,
                       input logic [2:0] ro, input logic cr);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.r = r; v.rs = 1'b0; v.lk = 1'b1;
            v.st = st; v.pr = pr; v.ro = ro; v.cr = cr; v.rc = 4'd0;
            vecs.push_back(v);
        end
    endtask

    localparam logic [13:0] RESET_VEC = {3'd0, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 4'd0};

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        // Clean lock with pll_locked tied high.
        add(3, 1'b1, 3'd0, 1'b1, 3'b111, 1'b0);
        add(3, 1'b0, 3'd0, 1'b1, 3'b111, 1'b0);
        add(1, 1'b0, 3'd1, 1'b0, 3'b111, 1'b0);
        add(8, 1'b0, 3'd2, 1'b0, 3'b111, 1'b0);
        add(2, 1'b0, 3'd3, 1'b0, 3'b110, 1'b0);
        add(2, 1'b0, 3'd3, 1'b0, 3'b100, 1'b0);
        add(2, 1'b0, 3'd4, 1'b0, 3'b000, 1'b1);

        @(negedge refclk);
        for (int i = 0; i < vecs.size(); i++) begin
            tick(vecs[i].r, vecs[i].rs, vecs[i].lk, 1'b0);
            report($sformatf("clean_vec%0d", i), dut_vec(),
                   {vecs[i].st, vecs[i].pr, vecs[i].ro, vecs[i].cr, 1'b0, 1'b0, vecs[i].rc});
        end

        // rst while in RUN.
        phase = "rst_in_run";
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        report("rst_in_run_values", dut_vec(), RESET_VEC);

        // Flapping lock: lock_s low after five STABLE cycles.
        phase = "flap";
        run_until(2, 20, 1'b1, "flap_reach_stable");
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("flap_still_stable", int'(state), 2);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("flap_back_to_reset", int'(state), 0);
        check_val("flap_retry", int'(retry_count), 1);
        run_until(4, 80, 1'b1, "flap_reach_run");
        check_val("flap_ready", int'(clocks_ready), 1);
        check_val("flap_retry_frozen", int'(retry_count), 1);

        // One-cycle lock drop in RUN.
        phase = "loss_in_run";
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("loss_not_yet", int'(lock_lost), 0);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        report("loss_pulse", dut_vec(), {3'd0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 4'd0});
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("loss_pulse_width", int'(lock_lost), 0);
        run_until(4, 80, 1'b1, "loss_rerun");

        // Timeout retries into FAULT.
        phase = "timeout";
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 108; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b1);
            if (i == 35)  check_val("timeout_wait_pll_rst", int'(pll_rst), 0);
            if (i == 36)  check_val("timeout_retry1", int'(retry_count), 1);
            if (i == 36)  check_val("timeout_repulse", int'(pll_rst), 1);
            if (i == 40)  check_val("timeout_repulse_len", int'(pll_rst), 0);
            if (i == 72)  check_val("timeout_retry2", int'(retry_count), 2);
            if (i == 107) check_val("timeout_last_wait", int'(state), 1);
        end
        report("timeout_fault", dut_vec(), {3'd5, 1'b1, 3'b111, 1'b0, 1'b0, 1'b1, 4'd2});
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("fault_ignores_lock", int'(state), 5);

        // restart from FAULT.
        phase = "restart";
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        report("restart_from_fault", dut_vec(), RESET_VEC);
        run_until(4, 80, 1'b1, "restart_rerun");

        // restart mid-RELEASE, coincident with a lock drop.
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        run_until(3, 40, 1'b1, "reach_release");
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        check_val("mid_release", int'(state), 3);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        report("restart_masks_loss", dut_vec(), RESET_VEC);
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        check_val("restart_no_late_pulse", int'(lock_lost), 0);
        run_until(4, 80, 1'b1, "release_restart_rerun");

        // rst while in STABLE.
        phase = "rst_in_stable";
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        run_until(2, 20, 1'b1, "reach_stable");
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        report("rst_in_stable_values", dut_vec(), RESET_VEC);
        run_until(4, 80, 1'b1, "rst_rerun");

        // Random traffic against the model.
        phase = "random";
        begin
            logic lk;
            lk = 1'b1;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(49) == 0) lk = ~lk;
                tick(($urandom_range(299) == 0), ($urandom_range(149) == 0), lk, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
